vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the demoscene pixel pipeline: horizontal and vertical position counters, hsync/vsync, active-video flag, line and frame strobes, and a free-running frame counter.
- Sits directly upstream of the colour/effect stage: that stage consumes hpos/vpos/display_on to compute RGB, and forwards hsync/vsync to the pads.
- Default timing is 640x480@60 on a 25.175/25.2 MHz pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, sync pulse level (0 = active-low, 1 = active-high)
FRAME_W, 8, frame counter width

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
en  in  1  pixel advance enable; counters and outputs hold when low
hpos  out  10  current column, 0..H_TOTAL-1
vpos  out  10  current line, 0..V_TOTAL-1
display_on  out  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE
hsync  out  1  horizontal sync, level per SYNC_ACTIVE
vsync  out  1  vertical sync, level per SYNC_ACTIVE
line_start  out  1  one-cycle strobe when hpos wraps to 0
frame_start  out  1  one-cycle strobe when (hpos,vpos) wraps to (0,0)
frame_cnt  out  FRAME_W  frame count, wraps modulo 2^FRAME_W

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Counter widths are fixed at 10 bits, so H_TOTAL and V_TOTAL must be ≤1024.
- Every output is a flop; there are no combinational paths from input to output.
- Sync, display_on and strobe outputs are decoded from the next counter values and registered. They are therefore cycle-aligned with the registered hpos/vpos.
- Reset (rst high at a clk edge; overrides en):
  - hpos=0, vpos=0, frame_cnt=0
  - display_on=0, line_start=0, frame_start=0
  - hsync=vsync=!SYNC_ACTIVE
- First enabled cycle after reset: hpos=1, vpos=0, display_on=1. Pixel (0,0) of frame 0 is blanked; this is accepted.
- Advance on each en=1 edge:
  - If hpos==H_TOTAL-1: hpos←0.
    - If vpos==V_TOTAL-1: vpos←0.
    - Otherwise: vpos←vpos+1.
  - Otherwise: hpos←hpos+1.
- hsync is at the active level iff H_ACTIVE+H_FP ≤ hpos < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
- vsync is at the active level iff V_ACTIVE+V_FP ≤ vpos < V_ACTIVE+V_FP+V_SYNC (490..491 by default). vsync is a whole-line decode: it changes only on edges where hpos becomes 0.
- line_start=1 for exactly the cycle in which the new hpos==0.
- frame_start=1 for exactly the cycle in which the new hpos==0 and new vpos==0. line_start is also 1 in that cycle.
- frame_cnt increments by 1 in the same edge that raises frame_start. It wraps from 2^FRAME_W-1 to 0.
- en=0:
  - All counters and levels hold.
  - line_start and frame_start are forced to 0; a strobe never repeats across a stall.
- Reset mid-frame: the next cycle shows reset values regardless of counter position or en. No frame_start strobe is emitted for a reset.
- No other state exists and no illegal counter values are reachable. Out-of-range values can only arise through a parameter error and are not handled.

Test Plan:
- Reset, then en=1 for 800 cycles → hpos goes 1..799 then 0; line_start pulses once at the hpos=0 cycle; vpos becomes 1 at that cycle.
- Default params, count hsync cycles in one line → exactly 96 cycles at level 0, first low at hpos=656, last low at hpos=751; display_on high for exactly 640 cycles per visible line.
- Run one full frame (420000 cycles) →
  - vsync low only for vpos 490..491 (1600 cycles);
  - frame_start pulses once, coincident with line_start, hpos=0, vpos=0;
  - frame_cnt goes 0→1.
- Toggle en low for 5 cycles at hpos=799, vpos=524, then high → all outputs frozen during the stall; on resume, hpos=0, vpos=0, frame_start=1 for a single cycle.
- Assert rst for 1 cycle at hpos=700, vpos=300, en=1 → next cycle hpos=0, vpos=0, display_on=0, hsync=vsync=1, frame_cnt=0, no strobes.
- Set FRAME_W=2 and run 4 frames → frame_cnt sequence 1,2,3,0; wraps without glitch.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle between the timing generator and the colour stage
interface vga_timing_if #(
  parameter int FRAME_W = 8
);
  logic               en;
  logic [9:0]         hpos;
  logic [9:0]         vpos;
  logic               display_on;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  modport master (
    input  en,
    output hpos, vpos, display_on, hsync, vsync, line_start, frame_start, frame_cnt
  );
  modport slave (
    output en,
    input  hpos, vpos, display_on, hsync, vsync, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync, blanking, strobes and frame count
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int FRAME_W     = 8
) (
  input logic           clk,
  input logic           rst,
  vga_timing_if.master  vga
);
  localparam logic [9:0] H_MAX = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS = 10'(V_ACTIVE);
  localparam logic [9:0] HS_0  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_1  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_0  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_1  = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic       h_wrap, v_wrap;
  logic [9:0] h_nxt, v_nxt;
  always_comb begin
    h_wrap = vga.hpos == H_MAX;
    v_wrap = vga.vpos == V_MAX;
    h_nxt  = h_wrap ? 10'd0 : vga.hpos + 10'd1;
    v_nxt  = h_wrap ? (v_wrap ? 10'd0 : vga.vpos + 10'd1) : vga.vpos;
  end
  // decode from the next counter values so levels line up with the registered hpos/vpos
  always_ff @(posedge clk) begin
    if (rst) begin
      vga.hpos        <= '0;
      vga.vpos        <= '0;
      vga.display_on  <= 1'b0;
      vga.hsync       <= !SYNC_ACTIVE;
      vga.vsync       <= !SYNC_ACTIVE;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.frame_cnt   <= '0;
    end else begin
      vga.line_start  <= vga.en && h_wrap;
      vga.frame_start <= vga.en && h_wrap && v_wrap;
      if (vga.en) begin
        vga.hpos       <= h_nxt;
        vga.vpos       <= v_nxt;
        vga.display_on <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        vga.hsync      <= (h_nxt >= HS_0 && h_nxt < HS_1) ? SYNC_ACTIVE : !SYNC_ACTIVE;
        vga.vsync      <= (v_nxt >= VS_0 && v_nxt < VS_1) ? SYNC_ACTIVE : !SYNC_ACTIVE;
        if (h_wrap && v_wrap) vga.frame_cnt <= vga.frame_cnt + 1'b1;
      end
    end
  end
endmodule
